// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding and datapath select codes for the multicycle ARM control unit
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_UNKNOWN
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/mainfsm_aludec.sv
// aludec: maps ALUOp and the cmd/S bits of Funct to ALUControl and the raw flag-write request
module aludec
  import mc_pkg::*;
(
  input  logic       alu_op,
  input  logic [4:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w
);

  logic [3:0] cmd;
  logic       known;
  logic [1:0] ctl;

  assign cmd = funct[4:1];

  // Unsupported commands fall back to ADD and never touch the flags; only ADD/SUB produce C/V
  always_comb begin
    known       = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) || (cmd == CMD_ORR);
    ctl         = (cmd == CMD_SUB) ? ALU_SUB : (cmd == CMD_AND) ? ALU_AND : (cmd == CMD_ORR) ? ALU_ORR : ALU_ADD;
    alu_control = alu_op ? ctl : ALU_ADD;
    flag_w      = (alu_op && known) ? {funct[0], funct[0] & ~ctl[1]} : 2'b00;
  end

endmodule

// File: rtl/mainfsm.sv
// mainfsm: Moore sequencer for fetch/decode/execute/writeback with ALU decode and PC-write request
module mainfsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  state_t     state_q, state_d;
  logic       irw, npc, regw, memw, branch, alu_op;
  logic [1:0] flag_w_raw;

  // Sequence through the instruction phases; the class is chosen in DECODE
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = (Op == OP_MEM) ? S_MEMADR :
                            (Op == OP_BR)  ? S_BRANCH :
                            (Op == OP_DP)  ? (Funct[5] ? S_EXECUTEI : S_EXECUTER) : S_UNKNOWN;
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; reset forces FETCH immediately so no pending writeback can complete
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Moore decode of selects and raw strobes from the current state
  always_comb begin
    irw       = 1'b0;
    npc       = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        irw       = 1'b1;
        npc       = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURES;
      end
      S_MEMADR:   ALUSrcB = SRCB_IMM;
      S_MEMRD:    AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        regw      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECUTER: alu_op = 1'b1;
      S_EXECUTEI: begin
        alu_op  = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ALUWB:    regw = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  aludec u_aludec (
    .alu_op      (alu_op),
    .funct       (Funct[4:0]),
    .alu_control (ALUControl),
    .flag_w      (flag_w_raw)
  );

  // Strobes are gated by reset so they drop the instant reset asserts, without waiting for a clock
  always_comb begin
    IRWrite = irw & rst;
    NextPC  = npc & rst;
    RegW    = regw & rst;
    MemW    = memw & rst;
    FlagW   = flag_w_raw & {2{rst}};
    PCS     = (branch | (regw & (Rd == 4'hF))) & rst;
    ImmSrc  = Op;
    RegSrc  = {Op == OP_MEM, Op == OP_BR};
  end

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: scoreboard bench comparing the full control word each cycle against hand-derived vectors
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] Op = 2'b01;
  logic [5:0] Funct = 6'b011001;
  logic [3:0] Rd = 4'd3;
  logic       PCS, RegW, MemW, IRWrite, NextPC, AdrSrc, ALUSrcA;
  logic [1:0] FlagW, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;

  logic [18:0] exp_q[$];
  string       nm_q[$];
  int          checks = 0;
  int          failures = 0;

  mainfsm dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Word layout: {PCS,RegW,MemW}, FlagW, {IRWrite,NextPC,AdrSrc,ALUSrcA}, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc
  function automatic logic [18:0] v(input logic [2:0] w, input logic [1:0] fw, input logic [3:0] c,
                                    input logic [1:0] sb, input logic [1:0] rs, input logic [1:0] ac,
                                    input logic [1:0] imm, input logic [1:0] rsrc);
    return {w, fw, c, sb, rs, ac, imm, rsrc};
  endfunction

  task automatic push(input logic [18:0] e, input string n);
    exp_q.push_back(e);
    nm_q.push_back(n);
  endtask

  task automatic step(input logic [18:0] e, input string n);
    @(posedge clk);
    #1;
    push(e, n);
  endtask

  task automatic fetch(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                       input logic [18:0] e, input string n);
    @(posedge clk);
    #1;
    Op = op;
    Funct = fn;
    Rd = rd;
    push(e, n);
  endtask

  // Monitor: samples away from the rising edge and also right after reset asserts
  initial begin
    logic [18:0] act, e;
    string n;
    forever begin
      @(negedge clk or negedge rst);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        act = {PCS, RegW, MemW, FlagW, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got %b want %b at %0t", n, act, e, $time);
        end
      end
    end
  end

  // Directed instruction stream
  initial begin
    logic [18:0] rst_m, fet_m, dec_m, madr, mrd, mwb, mwb15, mwr;
    logic [18:0] fet0, dec0, alwb, alwb15;
    rst_m  = v(3'b000, 2'b00, 4'b0001, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10);
    fet_m  = v(3'b000, 2'b00, 4'b1101, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10);
    dec_m  = v(3'b000, 2'b00, 4'b0001, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10);
    madr   = v(3'b000, 2'b00, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10);
    mrd    = v(3'b000, 2'b00, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10);
    mwb    = v(3'b010, 2'b00, 4'b0000, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10);
    mwb15  = v(3'b110, 2'b00, 4'b0000, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10);
    mwr    = v(3'b001, 2'b00, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10);
    fet0   = v(3'b000, 2'b00, 4'b1101, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    dec0   = v(3'b000, 2'b00, 4'b0001, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    alwb   = v(3'b010, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    alwb15 = v(3'b110, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < 3; i++) step(rst_m, "reset_hold");
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(fet_m, "fetch_after_reset");
    #6;
    rst = 1'b0;
    push(rst_m, "reset_pulse");
    #2;
    rst = 1'b1;

    step(dec_m, "ldr_decode");
    step(madr, "ldr_memadr");
    step(mrd, "ldr_memrd");
    step(mwb, "ldr_memwb");

    fetch(2'b01, 6'b011001, 4'hF, fet_m, "ldr15_fetch");
    step(dec_m, "ldr15_decode");
    step(madr, "ldr15_memadr");
    step(mrd, "ldr15_memrd");
    step(mwb15, "ldr15_memwb_pcs");

    fetch(2'b01, 6'b011000, 4'd3, fet_m, "str_fetch");
    step(dec_m, "str_decode");
    step(madr, "str_memadr");
    step(mwr, "str_memwr");

    fetch(2'b00, 6'b001001, 4'd2, fet0, "adds_fetch");
    step(dec0, "adds_decode");
    step(v(3'b000, 2'b11, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "adds_exec");
    step(alwb, "adds_aluwb");

    fetch(2'b00, 6'b111001, 4'd2, fet0, "orrs_fetch");
    step(dec0, "orrs_decode");
    step(v(3'b000, 2'b10, 4'b0000, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00), "orrs_execi");
    step(alwb, "orrs_aluwb");

    fetch(2'b00, 6'b000100, 4'hF, fet0, "sub_fetch");
    step(dec0, "sub_decode");
    step(v(3'b000, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00), "sub_nos_exec");
    step(alwb15, "sub_aluwb_pc");

    fetch(2'b00, 6'b000101, 4'd1, fet0, "subs_fetch");
    step(dec0, "subs_decode");
    step(v(3'b000, 2'b11, 4'b0000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00), "subs_exec");
    step(alwb, "subs_aluwb");

    fetch(2'b00, 6'b000001, 4'd1, fet0, "ands_fetch");
    step(dec0, "ands_decode");
    step(v(3'b000, 2'b10, 4'b0000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00), "ands_exec");
    step(alwb, "ands_aluwb");

    fetch(2'b00, 6'b000011, 4'd1, fet0, "eors_fetch");
    step(dec0, "eors_decode");
    step(v(3'b000, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "unsupported_cmd_exec");
    step(alwb, "eors_aluwb");

    fetch(2'b10, 6'b101010, 4'd0, v(3'b000, 2'b00, 4'b1101, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01), "b_fetch");
    step(v(3'b000, 2'b00, 4'b0001, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01), "b_decode");
    step(v(3'b100, 2'b00, 4'b0000, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01), "b_branch");

    fetch(2'b11, 6'b001001, 4'hF, v(3'b000, 2'b00, 4'b1101, 2'b10, 2'b10, 2'b00, 2'b11, 2'b00), "und_fetch");
    step(v(3'b000, 2'b00, 4'b0001, 2'b10, 2'b10, 2'b00, 2'b11, 2'b00), "und_decode");
    step(v(3'b000, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00), "und_unknown");

    fetch(2'b01, 6'b011001, 4'd3, fet_m, "ldr_r_fetch");
    step(dec_m, "ldr_r_decode");
    step(madr, "ldr_r_memadr");
    step(mrd, "ldr_r_memrd");
    #6;
    rst = 1'b0;
    push(rst_m, "reset_in_memrd");
    step(rst_m, "no_memwb_in_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(fet_m, "fetch_after_midreset");
    step(dec_m, "decode_after_midreset");

    repeat (2) @(posedge clk);
    #6;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
